// File: rtl/prog_seq.sv
// ---------------------------------------------------------------------------
// prog_seq : instruction sequencer (program memory, PC, bit index) for the
//            bit-serial decoder.                          rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prog_seq #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WRAP   = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_run,
  input  logic              i_halt,
  input  logic [ADDR_W-1:0] i_last_addr,
  input  logic              i_load_en,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [2:0]        i_load_data,
  input  logic              i_pcincr,
  output logic [2:0]        o_instr,
  output logic [2:0]        o_data_count,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_running,
  output logic              o_done,
  output logic              o_load_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam bit c_wrap = (WRAP != 0);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_last;
  logic [2:0]        r_bit_cnt;
  logic              r_done;
  logic              r_load_err;
  logic [2:0]        r_mem [DEPTH];

  logic              w_running;
  logic              w_at_last;
  logic              w_eop;
  logic              w_write;
  logic [ADDR_W-1:0] w_pc_adv;

  assign w_running = (r_state == S_RUN);
  assign w_at_last = (r_pc == r_last);
  assign w_eop     = w_running && i_pcincr && w_at_last && !c_wrap;
  assign w_write   = !i_rst && !w_running && i_load_en;

  always_comb begin
    w_pc_adv = r_pc + 1'b1;
    if (w_at_last) begin
      w_pc_adv = c_wrap ? '0 : r_pc;
    end
  end

  // Program memory is intentionally left out of reset so a program survives it.
  always_ff @(posedge i_clk) begin
    if (w_write) begin
      r_mem[i_load_addr] <= i_load_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_last     <= '0;
      r_bit_cnt  <= 3'd0;
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= w_running && i_load_en;
      case (r_state)
        S_RUN: begin
          if (i_pcincr) begin
            r_pc <= w_pc_adv;
          end
          r_bit_cnt <= (i_pcincr || i_halt) ? 3'd0 : r_bit_cnt + 3'd1;
          // End of program dominates a simultaneous halt for the done flag.
          if (i_halt || w_eop) begin
            r_state <= S_HALT;
            r_done  <= w_eop;
          end
        end
        default: begin
          r_bit_cnt <= 3'd0;
          if (i_run) begin
            r_state <= S_RUN;
            r_pc    <= '0;
            r_last  <= i_last_addr;
            r_done  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign o_instr      = w_running ? r_mem[r_pc] : 3'b000;
  assign o_data_count = r_bit_cnt;
  assign o_pc         = r_pc;
  assign o_running    = w_running;
  assign o_done       = (r_state == S_HALT) && r_done;
  assign o_load_err   = r_load_err;

endmodule

`default_nettype wire

// File: tb/tb_prog_seq.sv
// ---------------------------------------------------------------------------
// tb_prog_seq : bench for prog_seq, WRAP=0 and WRAP=1 instances side by side.
//                                                         rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_prog_seq;

  typedef struct {
    logic       rst, run, halt;
    logic [3:0] last;
    logic       ld;
    logic [3:0] la;
    logic [2:0] ld_d;
    logic       inc;
    logic [2:0] e_instr, e_cnt;
    logic [3:0] e_pc;
    logic       e_run, e_done, e_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1, run = 1'b0, halt = 1'b0, ld = 1'b0, inc = 1'b0;
  logic [3:0] last_addr = 4'd0, ld_addr = 4'd0;
  logic [2:0] ld_data = 3'd0;

  logic [2:0] i0, c0, i1, c1;
  logic [3:0] p0, p1;
  logic       r0, dn0, e0, r1, dn1, e1;

  int checks = 0;
  int failures = 0;

  int m_st[2], m_pc[2], m_cnt[2], m_last[2], m_done[2], m_err[2];
  int m_mem[2][16];

  always #5 clk = ~clk;

  prog_seq #(.DEPTH(16), .ADDR_W(4), .WRAP(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_halt(halt), .i_last_addr(last_addr),
    .i_load_en(ld), .i_load_addr(ld_addr), .i_load_data(ld_data), .i_pcincr(inc),
    .o_instr(i0), .o_data_count(c0), .o_pc(p0), .o_running(r0), .o_done(dn0),
    .o_load_err(e0)
  );

  prog_seq #(.DEPTH(16), .ADDR_W(4), .WRAP(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_halt(halt), .i_last_addr(last_addr),
    .i_load_en(ld), .i_load_addr(ld_addr), .i_load_data(ld_data), .i_pcincr(inc),
    .o_instr(i1), .o_data_count(c1), .o_pc(p1), .o_running(r1), .o_done(dn1),
    .o_load_err(e1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: states 0=idle 1=run 2=halt; instance k uses wrap=k.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int eop;
      if (rst) begin
        m_st[k] = 0; m_pc[k] = 0; m_cnt[k] = 0; m_last[k] = 0;
        m_done[k] = 0; m_err[k] = 0;
      end else begin
        m_err[k] = (m_st[k] == 1 && ld) ? 1 : 0;
        if (m_st[k] != 1 && ld) m_mem[k][ld_addr] = ld_data;
        if (m_st[k] == 1) begin
          eop = 0;
          if (inc) begin
            if (m_pc[k] == m_last[k]) begin
              if (k == 1) m_pc[k] = 0;
              else eop = 1;
            end else begin
              m_pc[k] = (m_pc[k] + 1) % 16;
            end
          end
          m_cnt[k] = (inc || halt) ? 0 : (m_cnt[k] + 1) % 8;
          if (halt || eop != 0) begin
            m_st[k] = 2;
            m_done[k] = eop;
          end
        end else begin
          m_cnt[k] = 0;
          if (run) begin
            m_st[k] = 1; m_pc[k] = 0; m_last[k] = last_addr; m_done[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic model_check();
    int ei0, ei1;
    ei0 = (m_st[0] == 1) ? m_mem[0][m_pc[0]] : 0;
    ei1 = (m_st[1] == 1) ? m_mem[1][m_pc[1]] : 0;
    chk("m0_instr", i0, ei0);  chk("m1_instr", i1, ei1);
    chk("m0_cnt", c0, m_cnt[0]); chk("m1_cnt", c1, m_cnt[1]);
    chk("m0_pc", p0, m_pc[0]);   chk("m1_pc", p1, m_pc[1]);
    chk("m0_running", r0, (m_st[0] == 1) ? 1 : 0);
    chk("m1_running", r1, (m_st[1] == 1) ? 1 : 0);
    chk("m0_done", dn0, (m_st[0] == 2 && m_done[0] != 0) ? 1 : 0);
    chk("m1_done", dn1, (m_st[1] == 2 && m_done[1] != 0) ? 1 : 0);
    chk("m0_load_err", e0, m_err[0]); chk("m1_load_err", e1, m_err[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    model_check();
  endtask

  task automatic clear_in();
    rst = 0; run = 0; halt = 0; ld = 0; inc = 0;
  endtask

  task automatic wait_cnt(input int inst, input int t);
    int w = 0;
    while (((inst == 0) ? int'(c0) : int'(c1)) != t && w < 16) begin
      tick();
      w++;
    end
    chk("wait_cnt", (inst == 0) ? c0 : c1, t);
  endtask

  task automatic pulse_inc();
    inc = 1; tick(); inc = 0;
  endtask

  function automatic vec_t mk(input logic r, input logic rn, input logic h,
                              input int la_, input logic l, input int a, input int d,
                              input logic in_, input int ei, input int ec, input int ep,
                              input logic er, input logic ed, input logic ee);
    vec_t v;
    v.rst = r; v.run = rn; v.halt = h; v.last = 4'(la_); v.ld = l; v.la = 4'(a);
    v.ld_d = 3'(d); v.inc = in_; v.e_instr = 3'(ei); v.e_cnt = 3'(ec);
    v.e_pc = 4'(ep); v.e_run = er; v.e_done = ed; v.e_err = ee;
    return v;
  endfunction

  vec_t tbl[19];
  int exp_i0[3] = '{4, 0, 0};
  int exp_p0[3] = '{1, 2, 2};

  initial begin
    // rst run halt last ld la d inc | instr cnt pc running done err  (WRAP=0 instance)
    tbl[0]  = mk(0,0,0,0, 0,0,0, 0,  0,0,0, 0,0,0);
    tbl[1]  = mk(0,1,0,2, 0,0,0, 0,  7,0,0, 1,0,0);
    tbl[2]  = mk(0,0,0,0, 0,0,0, 0,  7,1,0, 1,0,0);
    tbl[3]  = mk(0,0,0,0, 0,0,0, 1,  4,0,1, 1,0,0);
    tbl[4]  = mk(0,0,0,0, 0,0,0, 0,  4,1,1, 1,0,0);
    tbl[5]  = mk(0,0,0,0, 1,1,2, 0,  4,2,1, 1,0,1);
    tbl[6]  = mk(0,0,0,0, 0,0,0, 0,  4,3,1, 1,0,0);
    tbl[7]  = mk(0,0,0,0, 0,0,0, 1,  0,0,2, 1,0,0);
    tbl[8]  = mk(0,1,0,5, 0,0,0, 0,  0,1,2, 1,0,0);
    tbl[9]  = mk(0,0,0,0, 0,0,0, 1,  0,0,2, 0,1,0);
    tbl[10] = mk(0,0,0,0, 0,0,0, 1,  0,0,2, 0,1,0);
    tbl[11] = mk(0,1,0,2, 1,0,3, 0,  3,0,0, 1,0,0);
    tbl[12] = mk(0,0,1,0, 0,0,0, 1,  0,0,1, 0,0,0);
    tbl[13] = mk(0,0,0,0, 1,0,7, 0,  0,0,1, 0,0,0);
    tbl[14] = mk(0,1,0,1, 0,0,0, 0,  7,0,0, 1,0,0);
    tbl[15] = mk(0,1,1,0, 0,0,0, 0,  0,0,0, 0,0,0);
    tbl[16] = mk(0,1,0,0, 0,0,0, 0,  7,0,0, 1,0,0);
    tbl[17] = mk(0,0,1,0, 0,0,0, 1,  0,0,0, 0,1,0);
    tbl[18] = mk(1,1,0,0, 0,0,0, 0,  0,0,0, 0,0,0);

    rst = 1;
    tick(); tick();
    clear_in();
    for (int a = 0; a < 16; a++) begin
      ld = 1; ld_addr = 4'(a); ld_data = 3'((a * 3 + 1) % 8); tick();
    end
    for (int a = 0; a < 3; a++) begin
      ld = 1; ld_addr = 4'(a); ld_data = (a == 0) ? 3'd7 : (a == 1) ? 3'd4 : 3'd0; tick();
    end
    ld = 0;
    repeat (5) tick();
    chk("idle_instr", i0, 0); chk("idle_cnt", c0, 0); chk("idle_pc", p0, 0);
    chk("idle_running", r0, 0); chk("idle_done", dn0, 0);

    for (int n = 0; n < 19; n++) begin
      rst = tbl[n].rst; run = tbl[n].run; halt = tbl[n].halt; last_addr = tbl[n].last;
      ld = tbl[n].ld; ld_addr = tbl[n].la; ld_data = tbl[n].ld_d; inc = tbl[n].inc;
      tick();
      chk($sformatf("tbl%0d_instr", n), i0, tbl[n].e_instr);
      chk($sformatf("tbl%0d_cnt", n), c0, tbl[n].e_cnt);
      chk($sformatf("tbl%0d_pc", n), p0, tbl[n].e_pc);
      chk($sformatf("tbl%0d_running", n), r0, tbl[n].e_run);
      chk($sformatf("tbl%0d_done", n), dn0, tbl[n].e_done);
      chk($sformatf("tbl%0d_load_err", n), e0, tbl[n].e_err);
    end
    clear_in();

    // End of program versus wrap, pcincr on bit 7.
    run = 1; last_addr = 4'd2; tick(); run = 0;
    chk("seq_first_instr", i0, 7);
    for (int k = 0; k < 3; k++) begin
      wait_cnt(1, 7);
      pulse_inc();
      chk($sformatf("seq%0d_instr", k), i0, exp_i0[k]);
      chk($sformatf("seq%0d_pc", k), p0, exp_p0[k]);
    end
    chk("eop_done", dn0, 1); chk("eop_running", r0, 0);
    chk("wrap_pc", p1, 0); chk("wrap_instr", i1, 7);
    chk("wrap_running", r1, 1); chk("wrap_cnt", c1, 0);

    // Rejected write while running, then replay of word 1.
    ld = 1; ld_addr = 4'd1; ld_data = 3'd2; tick(); ld = 0;
    chk("lerr_pulse", e1, 1);
    tick();
    chk("lerr_clear", e1, 0);
    ld = 1; ld_addr = 4'd1; ld_data = 3'd4; tick(); ld = 0;
    wait_cnt(1, 7);
    pulse_inc();
    chk("replay_word1", i1, 4);
    rst = 1; tick(); rst = 0;

    // Halt coinciding with pcincr.
    run = 1; last_addr = 4'd2; tick(); run = 0;
    wait_cnt(0, 7);
    pulse_inc();
    chk("halt_pre_pc", p0, 1);
    wait_cnt(0, 4);
    halt = 1; inc = 1; tick(); halt = 0; inc = 0;
    chk("halt_pc", p0, 2); chk("halt_cnt", c0, 0);
    chk("halt_done", dn0, 0); chk("halt_running", r0, 0);
    run = 1; tick(); run = 0;
    chk("restart_pc", p0, 0); chk("restart_instr", i0, 7);

    // Reset in the middle of an instruction.
    wait_cnt(0, 7);
    pulse_inc();
    wait_cnt(0, 5);
    chk("mid_pc", p0, 1);
    rst = 1; tick(); rst = 0;
    chk("rst_pc", p0, 0); chk("rst_cnt", c0, 0); chk("rst_running", r0, 0);
    run = 1; last_addr = 4'd2; tick(); run = 0;
    chk("rst_replay0", i0, 7);
    wait_cnt(0, 7);
    pulse_inc();
    chk("rst_replay1", i0, 4);

    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      run       = ($urandom_range(0, 15) == 0);
      halt      = ($urandom_range(0, 39) == 0);
      inc       = ($urandom_range(0, 3) == 0);
      ld        = ($urandom_range(0, 7) == 0);
      last_addr = 4'($urandom_range(0, 15));
      ld_addr   = 4'($urandom_range(0, 15));
      ld_data   = 3'($urandom_range(0, 7));
      tick();
    end
    clear_in();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prog_seq.md
Name: prog_seq

Overview:
- Instruction sequencer for the bit-serial datapath; the supplier end of the decoder's instruction/bit-count interface.
- Holds a small loadable 3-bit program memory and a program counter (PC).
- Presents the current instruction and a free-running 0..7 bit index to the decoder.
- Advances the PC when the decoder raises its PC-increment strobe. Handles program start, halt and end-of-program.

Parameters:
- DEPTH, 16, number of 3-bit program words.
- ADDR_W, 4, address width; must equal clog2(DEPTH).
- WRAP, 0: 1 = loop back to address 0 after the last instruction; 0 = halt after it.

Ports:
- i_clk  input  1  clock, all state changes on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_run  input  1  start pulse; honoured in IDLE or HALT
- i_halt  input  1  stop request; honoured in RUN
- i_last_addr  input  ADDR_W  address of the final program word; sampled when i_run is accepted
- i_load_en  input  1  program-memory write strobe
- i_load_addr  input  ADDR_W  write address
- i_load_data  input  3  instruction word to write
- i_pcincr  input  1  decoder strobe: current instruction finished
- o_instr  output  3  instruction to decoder
- o_data_count  output  3  bit index to decoder
- o_pc  output  ADDR_W  current program counter
- o_running  output  1  high in RUN
- o_done  output  1  high in HALT entered by end of program
- o_load_err  output  1  one-cycle pulse when a write is rejected

Behaviour:
- Reset (i_rst high at an edge):
  - state=IDLE, pc=0, bit counter=0, last-address register=0.
  - o_done=0, o_load_err=0, o_running=0.
  - Memory contents are not reset.
  - Reset overrides every other input, including mid-instruction.
- States:
  - IDLE, RUN and HALT.
  - HALT carries a done flag: set when entered by end of program, cleared when entered by i_halt.
- Outputs by state:
  - o_instr is combinational: mem[pc] in RUN, 3'b000 (NOP) in IDLE and HALT.
  - o_data_count = bit counter; o_pc = pc.
  - o_running = (state==RUN); o_done = HALT with done flag set.
- Program load:
  - When i_load_en=1 in IDLE or HALT, mem[i_load_addr] <= i_load_data at the edge.
  - Readable through o_instr once in RUN.
  - When i_load_en=1 in RUN, the write is dropped and o_load_err=1 on the following cycle only.
- Start:
  - i_run in IDLE or HALT → next cycle: RUN, pc=0, bit counter=0, last-address register=i_last_addr, done flag cleared.
  - i_run in RUN is ignored.
- Bit counter:
  - In RUN it increments by 1 every cycle and wraps 7→0.
  - It holds at 0 outside RUN.
- PC advance (in RUN, i_pcincr=1):
  - bit counter <= 0 on the next edge (the new instruction starts at bit 0).
  - If pc != last: pc <= pc+1.
  - If pc == last and WRAP=1: pc <= 0; stay in RUN.
  - If pc == last and WRAP=0: state <= HALT with done flag set; pc holds at last.
- PC advance outside RUN: i_pcincr is ignored.
- pc arithmetic: modulo 2^ADDR_W. A last-address value ≥ DEPTH is legal but words beyond DEPTH are undefined.
- Halt:
  - i_halt in RUN → HALT next cycle, done flag clear.
  - pc holds, or takes its advanced value if i_pcincr was high in the same cycle.
  - Bit counter is forced to 0.
- Simultaneous events:
  - i_halt and i_run together in RUN: halt wins.
  - i_halt and end-of-program i_pcincr together: done flag set.
  - i_run and i_load_en together in IDLE or HALT: the write is performed and the run starts. A write to address 0 is visible on the first RUN cycle.
- Latency: PC change is visible on o_instr exactly one cycle after the i_pcincr edge.
- No combinational path from i_pcincr to any output.

Test Plan:
- Reset, then idle 5 cycles → o_instr=000, o_data_count=0, o_pc=0, o_running=0, o_done=0.
- Load program 111,100,000 at addresses 0..2; i_run with i_last_addr=2; pulse i_pcincr when o_data_count=7 each time → o_instr sequence 111,100,000, o_pc 0→1→2. After the third pulse, o_done=1 and o_instr=000 (WRAP=0).
- Same program with WRAP=1 → after the pcincr at pc=2, o_pc=0, o_instr=111, o_running stays 1, bit counter restarts at 0.
- In RUN, pulse i_load_en with addr 1, data 010 → o_load_err=1 for exactly one cycle; mem[1] unchanged (still 100 on replay).
- In RUN at pc=1, bit count 4, assert i_halt and i_pcincr together → next cycle state HALT, o_pc=2, o_data_count=0, o_done=0. Then i_run → o_pc=0.
- Assert i_rst mid-instruction (pc=1, count=5) → next cycle IDLE, pc=0, count=0. After a new i_run without reloading, the previously loaded program replays unchanged.
